// File: rtl/zap_decode_uop_fsm.sv
// Decode front end: splits BL (and BLX Rm when ZAP_BLX_EXPAND_EN is defined) into a
// link-write uop followed by a plain branch uop, holding fetch for the extra cycle.
module zap_decode_uop_fsm #(
    parameter int INS_WD = 35,
    parameter int T_BIT  = 5,
    parameter int CNT_WD = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fiq,
    input  logic              i_irq,
    input  logic [31:0]       i_cpsr_ff,
    input  logic              i_clear_from_writeback,
    input  logic              i_data_stall,
    input  logic              i_clear_from_alu,
    input  logic              i_stall_from_shifter,
    input  logic              i_stall_from_issue,
    input  logic [INS_WD-1:0] i_instruction,
    input  logic              i_instruction_valid,
    output logic [INS_WD-1:0] o_instruction,
    output logic              o_instruction_valid,
    output logic              o_uop_idx,
    output logic              o_uop_last,
    output logic              o_stall_from_decode,
    output logic              o_fiq,
    output logic              o_irq,
    output logic [CNT_WD-1:0] o_expand_cnt,
    output logic              o_dbg_state
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LINK = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [CNT_WD-1:0] r_expand_cnt;
    logic              w_is_bl;
    logic              w_is_blx;
    logic              w_expand;
    logic              w_unused_cpsr;
    logic [3:0]        w_cond;
    logic [INS_WD-1:0] w_link_uop;
    logic [INS_WD-1:0] w_branch_uop;

    assign w_cond  = i_instruction[31:28];
    assign w_is_bl = (i_instruction[27:25] == 3'b101) && i_instruction[24];
`ifdef ZAP_BLX_EXPAND_EN
    assign w_is_blx = (i_instruction[27:4] == 24'h12FFF3);
`else
    assign w_is_blx = 1'b0;
`endif
    assign w_expand      = w_is_bl | w_is_blx;
    assign w_unused_cpsr = ^i_cpsr_ff;

    // Link uop is SUB LR, PC, #4 (ARM) or #2 (Thumb) under the original condition.
    assign w_link_uop = {i_instruction[INS_WD-1:32], w_cond,
                         i_cpsr_ff[T_BIT] ? 28'h24FE002 : 28'h24FE004};

    // The fetch input is held during S_LINK, so the branch uop is rebuilt from it.
    assign w_branch_uop = w_is_blx ?
        {i_instruction[INS_WD-1:32], w_cond, 24'h12FFF1, i_instruction[3:0]} :
        {i_instruction[INS_WD-1:32], w_cond, i_instruction[27:25], 1'b0, i_instruction[23:0]};

    always_comb begin
        o_instruction       = i_instruction;
        o_instruction_valid = i_instruction_valid;
        o_uop_idx           = 1'b0;
        o_uop_last          = 1'b1;
        o_stall_from_decode = 1'b0;
        o_fiq               = i_fiq;
        o_irq               = i_irq;
        w_state_nxt         = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_instruction_valid && w_expand) begin
                    o_instruction       = w_link_uop;
                    o_stall_from_decode = 1'b1;
                    o_uop_last          = 1'b0;
                    o_fiq               = 1'b0;
                    o_irq               = 1'b0;
                    w_state_nxt         = S_LINK;
                end
            end
            S_LINK: begin
                o_uop_idx = 1'b1;
                o_fiq     = 1'b0;
                o_irq     = 1'b0;
                if (i_instruction_valid) begin
                    o_instruction = w_branch_uop;
                    w_state_nxt   = S_IDLE;
                end else begin
                    o_stall_from_decode = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clears never touch the counter; only reset does.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_expand_cnt <= '0;
        end else if (i_clear_from_writeback) begin
            r_state <= S_IDLE;
        end else if (i_data_stall) begin
            r_state <= r_state;
        end else if (i_clear_from_alu) begin
            r_state <= S_IDLE;
        end else if (i_stall_from_shifter || i_stall_from_issue) begin
            r_state <= r_state;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_LINK && w_state_nxt == S_IDLE && !(&r_expand_cnt))
                r_expand_cnt <= r_expand_cnt + CNT_WD'(1);
        end
    end

    assign o_expand_cnt = r_expand_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_zap_decode_uop_fsm.sv
// Bench for zap_decode_uop_fsm: per-cycle stimulus and expected outputs are queued,
// then each scenario task replays them and compares after the combinational settle.
module tb_zap_decode_uop_fsm;

    localparam int INS_WD = 35;
    localparam int CNT_WD = 4;
    localparam int W      = 6 + CNT_WD + INS_WD;
    localparam int B_IDX  = INS_WD + CNT_WD + 3;
    localparam int B_LAST = INS_WD + CNT_WD + 2;

    typedef struct packed {
        logic              rst;
        logic              clr_wb;
        logic              dstall;
        logic              clr_alu;
        logic              sh;
        logic              iss;
        logic              irq;
        logic              fiq;
        logic              t;
        logic              vld;
        logic [INS_WD-1:0] ins;
    } stim_t;

    logic              clk = 1'b0;
    logic              i_reset, i_fiq, i_irq;
    logic [31:0]       i_cpsr_ff;
    logic              i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic              i_stall_from_shifter, i_stall_from_issue;
    logic [INS_WD-1:0] i_instruction;
    logic              i_instruction_valid;
    logic [INS_WD-1:0] o_instruction;
    logic              o_instruction_valid, o_uop_idx, o_uop_last, o_stall_from_decode;
    logic              o_fiq, o_irq, o_dbg_state;
    logic [CNT_WD-1:0] o_expand_cnt;
    logic [W-1:0]      w_obs;

    stim_t             stim_q[$];
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      msk_q[$];
    logic [CNT_WD-1:0] exp_cnt;
    int                n_checks = 0;
    int                n_fail   = 0;

    zap_decode_uop_fsm #(.INS_WD(INS_WD), .T_BIT(5), .CNT_WD(CNT_WD)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_fiq(i_fiq), .i_irq(i_irq), .i_cpsr_ff(i_cpsr_ff),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_instruction(i_instruction),
        .i_instruction_valid(i_instruction_valid), .o_instruction(o_instruction),
        .o_instruction_valid(o_instruction_valid), .o_uop_idx(o_uop_idx),
        .o_uop_last(o_uop_last), .o_stall_from_decode(o_stall_from_decode),
        .o_fiq(o_fiq), .o_irq(o_irq), .o_expand_cnt(o_expand_cnt), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    assign w_obs = {o_instruction_valid, o_stall_from_decode, o_uop_idx, o_uop_last,
                    o_irq, o_fiq, o_expand_cnt, o_instruction};

    function automatic logic [W-1:0] ex(input logic v, input logic st, input logic idx,
                                        input logic last, input logic irq, input logic fiq,
                                        input logic [CNT_WD-1:0] c, input logic [INS_WD-1:0] ins);
        return {v, st, idx, last, irq, fiq, c, ins};
    endfunction

    function automatic logic [W-1:0] m_all();
        return '1;
    endfunction

    // S_LINK without a valid input: only valid/stall/irq/fiq/count are defined.
    function automatic logic [W-1:0] m_nodata();
        logic [W-1:0] m;
        m = '1;
        m[INS_WD-1:0] = '0;
        m[B_IDX]  = 1'b0;
        m[B_LAST] = 1'b0;
        return m;
    endfunction

    function automatic stim_t mk(input logic v, input logic [INS_WD-1:0] ins, input logic t,
                                 input logic irq, input logic fiq);
        stim_t s;
        s = '0;
        s.vld = v;
        s.ins = ins;
        s.t   = t;
        s.irq = irq;
        s.fiq = fiq;
        return s;
    endfunction

    function automatic void add(input stim_t s, input logic [W-1:0] e, input logic [W-1:0] m);
        stim_q.push_back(s);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endfunction

    function automatic logic [CNT_WD-1:0] inc(input logic [CNT_WD-1:0] c);
        return (c == '1) ? c : c + CNT_WD'(1);
    endfunction

    function automatic logic [INS_WD-1:0] rand_bl();
        return {3'($urandom_range(0, 7)), 4'($urandom_range(0, 14)), 4'b1011, 24'($urandom)};
    endfunction

    function automatic logic [INS_WD-1:0] rand_plain();
        logic [INS_WD-1:0] r;
        r = {3'($urandom_range(0, 7)), 32'($urandom)};
        r[27:25] = 3'b000;
        r[7:4]   = 4'h0;
        return r;
    endfunction

    function automatic logic [INS_WD-1:0] link_of(input logic [INS_WD-1:0] ins, input logic t);
        return {ins[INS_WD-1:28], t ? 28'h24FE002 : 28'h24FE004};
    endfunction

    function automatic logic [INS_WD-1:0] bl_branch(input logic [INS_WD-1:0] ins);
        logic [INS_WD-1:0] r;
        r = ins;
        r[24] = 1'b0;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        i_reset                = s.rst;
        i_clear_from_writeback = s.clr_wb;
        i_data_stall           = s.dstall;
        i_clear_from_alu       = s.clr_alu;
        i_stall_from_shifter   = s.sh;
        i_stall_from_issue     = s.iss;
        i_irq                  = s.irq;
        i_fiq                  = s.fiq;
        i_cpsr_ff              = $urandom;
        i_cpsr_ff[5]           = s.t;
        i_instruction_valid    = s.vld;
        i_instruction          = s.ins;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] e, m;
        stim_t s;
        logic [INS_WD-1:0] p;
        p = rand_plain();
        s = mk(0, p, 0, 1, 1);
        s.rst = 1'b1;
        exp_cnt = '0;
        add(s, ex(0, 0, 0, 1, 1, 1, exp_cnt, p), m_all());
        p = rand_plain();
        add(mk(1, p, 0, 0, 1), ex(1, 0, 0, 1, 0, 1, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL reset: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
        n_checks++;
        if (o_dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, expected 0", o_dbg_state);
        end
    endtask

    task automatic test_passthrough();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] p;
        logic v, ir, fq;
        for (int i = 0; i < 6; i++) begin
            p  = rand_plain();
            v  = 1'($urandom_range(0, 1));
            ir = 1'($urandom_range(0, 1));
            fq = 1'($urandom_range(0, 1));
            add(mk(v, p, 1'($urandom_range(0, 1)), ir, fq), ex(v, 0, 0, 1, ir, fq, exp_cnt, p), m_all());
        end
        p = rand_bl();
        add(mk(0, p, 0, 1, 0), ex(0, 0, 0, 1, 1, 0, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL passthrough: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_bl_arm();
        logic [W-1:0] e, m;
        logic [2:0] sb;
        logic [INS_WD-1:0] p;
        sb = 3'($urandom_range(0, 7));
        add(mk(1, {sb, 32'hEB000010}, 0, 1, 1), ex(1, 1, 0, 0, 0, 0, exp_cnt, {sb, 32'hE24FE004}), m_all());
        add(mk(1, {sb, 32'hEB000010}, 0, 1, 1), ex(1, 0, 1, 1, 0, 0, exp_cnt, {sb, 32'hEA000010}), m_all());
        exp_cnt = inc(exp_cnt);
        p = rand_plain();
        add(mk(0, p, 0, 1, 1), ex(0, 0, 0, 1, 1, 1, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL bl_arm: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_bl_thumb();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] p;
        add(mk(1, {3'b101, 32'h1B000004}, 1, 0, 1), ex(1, 1, 0, 0, 0, 0, exp_cnt, {3'b101, 32'h124FE002}), m_all());
        add(mk(1, {3'b101, 32'h1B000004}, 1, 0, 1), ex(1, 0, 1, 1, 0, 0, exp_cnt, {3'b101, 32'h1A000004}), m_all());
        exp_cnt = inc(exp_cnt);
        p = rand_plain();
        add(mk(0, p, 1, 0, 0), ex(0, 0, 0, 1, 0, 0, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL bl_thumb: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_holds();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] b, p;
        stim_t s;
        // Issue stall holds the link uop in place for three cycles.
        b = rand_bl();
        s = mk(1, b, 0, 0, 0);
        s.iss = 1'b1;
        for (int i = 0; i < 3; i++) add(s, ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        s.iss = 1'b0;
        add(s, ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        add(s, ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        exp_cnt = inc(exp_cnt);
        // Data and shifter holds in S_LINK keep the branch uop pending, no count.
        b = rand_bl();
        s = mk(1, b, 1, 1, 1);
        add(s, ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 1)), m_all());
        s.dstall = 1'b1;
        add(s, ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        s.dstall = 1'b0;
        s.sh     = 1'b1;
        add(s, ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        s.sh = 1'b0;
        add(s, ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        exp_cnt = inc(exp_cnt);
        // Bubble in S_LINK keeps the stall up and waits.
        b = rand_bl();
        add(mk(1, b, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        add(mk(0, b, 0, 1, 1), ex(0, 1, 0, 0, 0, 0, exp_cnt, '0), m_nodata());
        add(mk(1, b, 0, 1, 1), ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        exp_cnt = inc(exp_cnt);
        p = rand_plain();
        add(mk(0, p, 0, 0, 1), ex(0, 0, 0, 1, 0, 1, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL holds: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] b, p;
        stim_t s;
        // ALU flush after the link uop drops the branch uop.
        b = rand_bl();
        p = rand_plain();
        add(mk(1, b, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        s = mk(0, p, 0, 0, 0);
        s.clr_alu = 1'b1;
        add(s, ex(0, 1, 0, 0, 0, 0, exp_cnt, '0), m_nodata());
        add(mk(0, p, 0, 1, 0), ex(0, 0, 0, 1, 1, 0, exp_cnt, p), m_all());
        // Writeback flush outranks a data stall.
        b = rand_bl();
        add(mk(1, b, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        s = mk(0, p, 0, 0, 0);
        s.clr_wb = 1'b1;
        s.dstall = 1'b1;
        add(s, ex(0, 1, 0, 0, 0, 0, exp_cnt, '0), m_nodata());
        add(mk(0, p, 0, 0, 1), ex(0, 0, 0, 1, 0, 1, exp_cnt, p), m_all());
        // Data stall outranks an ALU flush: still in S_LINK afterwards.
        b = rand_bl();
        add(mk(1, b, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        s = mk(0, p, 0, 0, 0);
        s.dstall  = 1'b1;
        s.clr_alu = 1'b1;
        add(s, ex(0, 1, 0, 0, 0, 0, exp_cnt, '0), m_nodata());
        add(mk(0, p, 0, 1, 1), ex(0, 1, 0, 0, 0, 0, exp_cnt, '0), m_nodata());
        add(mk(1, b, 0, 1, 1), ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        exp_cnt = inc(exp_cnt);
        add(mk(0, p, 0, 1, 1), ex(0, 0, 0, 1, 1, 1, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL clear: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_blx();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] p;
`ifdef ZAP_BLX_EXPAND_EN
        add(mk(1, {3'b011, 32'hE12FFF33}, 0, 1, 1), ex(1, 1, 0, 0, 0, 0, exp_cnt, {3'b011, 32'hE24FE004}), m_all());
        add(mk(1, {3'b011, 32'hE12FFF33}, 0, 1, 1), ex(1, 0, 1, 1, 0, 0, exp_cnt, {3'b011, 32'hE12FFF13}), m_all());
        exp_cnt = inc(exp_cnt);
`else
        add(mk(1, {3'b011, 32'hE12FFF33}, 0, 1, 1), ex(1, 0, 0, 1, 1, 1, exp_cnt, {3'b011, 32'hE12FFF33}), m_all());
`endif
        p = rand_plain();
        add(mk(0, p, 0, 0, 0), ex(0, 0, 0, 1, 0, 0, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL blx: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] b, p;
        logic t;
        for (int i = 0; i < 18; i++) begin
            b = rand_bl();
            t = 1'($urandom_range(0, 1));
            add(mk(1, b, t, 0, 0), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, t)), m_all());
            add(mk(1, b, t, 0, 0), ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
            exp_cnt = inc(exp_cnt);
        end
        p = rand_plain();
        add(mk(0, p, 0, 0, 0), ex(0, 0, 0, 1, 0, 0, {CNT_WD{1'b1}}, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL saturation: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_reset_mid_link();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] b, p;
        stim_t s;
        b = rand_bl();
        p = rand_plain();
        add(mk(1, b, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, 0)), m_all());
        s = mk(1, b, 0, 0, 0);
        s.rst = 1'b1;
        add(s, ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
        exp_cnt = '0;
        add(mk(0, p, 0, 1, 0), ex(0, 0, 0, 1, 1, 0, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL reset_mid_link: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, m;
        logic [INS_WD-1:0] b, p;
        logic t, ir, fq;
        for (int i = 0; i < 20; i++) begin
            t  = 1'($urandom_range(0, 1));
            ir = 1'($urandom_range(0, 1));
            fq = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                b = rand_bl();
                add(mk(1, b, t, ir, fq), ex(1, 1, 0, 0, 0, 0, exp_cnt, link_of(b, t)), m_all());
                add(mk(1, b, t, ir, fq), ex(1, 0, 1, 1, 0, 0, exp_cnt, bl_branch(b)), m_all());
                exp_cnt = inc(exp_cnt);
            end else begin
                p = rand_plain();
                add(mk(1, p, t, ir, fq), ex(1, 0, 0, 1, ir, fq, exp_cnt, p), m_all());
            end
        end
        p = rand_plain();
        add(mk(0, p, 0, 0, 0), ex(0, 0, 0, 1, 0, 0, exp_cnt, p), m_all());
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_checks++;
            if ((w_obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL back_to_back: got %h, expected %h (mask %h)", w_obs, e, m);
            end
        end
    endtask

    initial begin
        i_reset                = 1'b1;
        i_fiq                  = 1'b0;
        i_irq                  = 1'b0;
        i_cpsr_ff              = '0;
        i_clear_from_writeback = 1'b0;
        i_data_stall           = 1'b0;
        i_clear_from_alu       = 1'b0;
        i_stall_from_shifter   = 1'b0;
        i_stall_from_issue     = 1'b0;
        i_instruction          = '0;
        i_instruction_valid    = 1'b0;
        exp_cnt                = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_bl_arm();
        test_bl_thumb();
        test_holds();
        test_clear();
        test_blx();
        test_saturation();
        test_reset_mid_link();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
